// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port round-robin arbiter in front of the sdram_controller port
module dram_arbiter #(
    parameter int ADDR_BITS      = 24,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   req0_cs,
    input  logic                   req0_read0_write1,
    input  logic [ADDR_BITS-1:0]   req0_addr,
    input  logic [XLEN/8-1:0]      req0_byteenable,
    input  logic [XLEN-1:0]        req0_write_data,
    output logic                   req0_ack,
    output logic [XLEN-1:0]        req0_read_data,
    input  logic                   req1_cs,
    input  logic                   req1_read0_write1,
    input  logic [ADDR_BITS-1:0]   req1_addr,
    input  logic [XLEN/8-1:0]      req1_byteenable,
    input  logic [XLEN-1:0]        req1_write_data,
    output logic                   req1_ack,
    output logic [XLEN-1:0]        req1_read_data,
    output logic                   mem_cs,
    output logic                   mem_read0_write1,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [XLEN/8-1:0]      mem_byteenable,
    output logic [XLEN-1:0]        mem_write_data,
    input  logic                   mem_ack,
    input  logic [XLEN-1:0]        mem_read_data,
    output logic                   busy,
    output logic                   grant_id,
    output logic                   timeout_error,
    output logic [1:0]             protocol_error
);

    localparam int BE_BITS   = XLEN / 8;
    // Counter wide enough to hold TIMEOUT_CYCLES-1; at least one bit when the watchdog is off.
    localparam int CW        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
    localparam bit   WDOG_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]                     pending_q, pending_d;
    logic [1:0]                     hold_rw_q, hold_rw_d;
    logic [1:0][ADDR_BITS-1:0]      hold_addr_q, hold_addr_d;
    logic [1:0][BE_BITS-1:0]        hold_be_q, hold_be_d;
    logic [1:0][XLEN-1:0]           hold_wd_q, hold_wd_d;

    logic                           last_grant_q, last_grant_d;
    logic                           grant_id_q, grant_id_d;
    logic                           mem_rw_q, mem_rw_d;
    logic [ADDR_BITS-1:0]           mem_addr_q, mem_addr_d;
    logic [BE_BITS-1:0]             mem_be_q, mem_be_d;
    logic [XLEN-1:0]                mem_wd_q, mem_wd_d;

    logic [1:0]                     ack_q, ack_d;
    logic [1:0][XLEN-1:0]           rdata_q, rdata_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           timeout_error_q, timeout_error_d;
    logic [1:0]                     protocol_error_q, protocol_error_d;

    // Live request fields gathered into per-port arrays so both ports share one code path.
    logic [1:0]                     req_cs;
    logic [1:0]                     live_rw;
    logic [1:0][ADDR_BITS-1:0]      live_addr;
    logic [1:0][BE_BITS-1:0]        live_be;
    logic [1:0][XLEN-1:0]           live_wd;

    assign req_cs       = {req1_cs, req0_cs};
    assign live_rw      = {req1_read0_write1, req0_read0_write1};
    assign live_addr[0] = req0_addr;
    assign live_addr[1] = req1_addr;
    assign live_be[0]   = req0_byteenable;
    assign live_be[1]   = req1_byteenable;
    assign live_wd[0]   = req0_write_data;
    assign live_wd[1]   = req1_write_data;

    // A port is a candidate if it is already waiting or is pulsing cs right now;
    // on a tie the port that did not win last time goes next.
    logic [1:0] cand;
    logic       pick;
    logic       timeout_hit;
    logic       finish;

    assign cand        = pending_q | req_cs;
    assign pick        = (cand == 2'b11) ? ~last_grant_q : cand[1];
    assign timeout_hit = WDOG_EN && (state_q == S_WAIT_ACK) && (cnt_q == TO_LAST) && !mem_ack;
    assign finish      = (state_q == S_WAIT_ACK) && (mem_ack || timeout_hit);

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q          <= S_IDLE;
            pending_q        <= '0;
            hold_rw_q        <= '0;
            hold_addr_q      <= '0;
            hold_be_q        <= '0;
            hold_wd_q        <= '0;
            last_grant_q     <= 1'b1;
            grant_id_q       <= 1'b0;
            mem_rw_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_be_q         <= '0;
            mem_wd_q         <= '0;
            ack_q            <= '0;
            rdata_q          <= '0;
            cnt_q            <= '0;
            timeout_error_q  <= 1'b0;
            protocol_error_q <= '0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            hold_rw_q        <= hold_rw_d;
            hold_addr_q      <= hold_addr_d;
            hold_be_q        <= hold_be_d;
            hold_wd_q        <= hold_wd_d;
            last_grant_q     <= last_grant_d;
            grant_id_q       <= grant_id_d;
            mem_rw_q         <= mem_rw_d;
            mem_addr_q       <= mem_addr_d;
            mem_be_q         <= mem_be_d;
            mem_wd_q         <= mem_wd_d;
            ack_q            <= ack_d;
            rdata_q          <= rdata_d;
            cnt_q            <= cnt_d;
            timeout_error_q  <= timeout_error_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // Next-state logic: IDLE grants, ISSUE lasts one cycle, WAIT_ACK ends on ack or watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (|cand) state_d = S_ISSUE;
            S_ISSUE:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: if (finish) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Holding registers, grant capture, watchdog counter and completion steering.
    always_comb begin
        pending_d        = pending_q;
        hold_rw_d        = hold_rw_q;
        hold_addr_d      = hold_addr_q;
        hold_be_d        = hold_be_q;
        hold_wd_d        = hold_wd_q;
        last_grant_d     = last_grant_q;
        grant_id_d       = grant_id_q;
        mem_rw_d         = mem_rw_q;
        mem_addr_d       = mem_addr_q;
        mem_be_d         = mem_be_q;
        mem_wd_d         = mem_wd_q;
        ack_d            = '0;
        rdata_d          = rdata_q;
        cnt_d            = cnt_q;
        timeout_error_d  = timeout_error_q;
        protocol_error_d = protocol_error_q;

        for (int n = 0; n < 2; n++) begin
            if (req_cs[n]) begin
                if (pending_q[n]) begin
                    protocol_error_d[n] = 1'b1;
                end else begin
                    pending_d[n]   = 1'b1;
                    hold_rw_d[n]   = live_rw[n];
                    hold_addr_d[n] = live_addr[n];
                    hold_be_d[n]   = live_be[n];
                    hold_wd_d[n]   = live_wd[n];
                end
            end
        end

        if ((state_q == S_IDLE) && (|cand)) begin
            grant_id_d   = pick;
            last_grant_d = pick;
            if (pending_q[pick]) begin
                mem_rw_d   = hold_rw_q[pick];
                mem_addr_d = hold_addr_q[pick];
                mem_be_d   = hold_be_q[pick];
                mem_wd_d   = hold_wd_q[pick];
            end else begin
                mem_rw_d   = live_rw[pick];
                mem_addr_d = live_addr[pick];
                mem_be_d   = live_be[pick];
                mem_wd_d   = live_wd[pick];
            end
        end

        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT_ACK) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (finish) begin
            ack_d[grant_id_q]     = 1'b1;
            rdata_d[grant_id_q]   = mem_ack ? mem_read_data : '0;
            pending_d[grant_id_q] = 1'b0;
            if (!mem_ack) begin
                timeout_error_d = 1'b1;
            end
        end
    end

    // FSM outputs: the command strobe lives only in ISSUE.
    always_comb begin
        mem_cs = (state_q == S_ISSUE);
        busy   = (state_q != S_IDLE);
    end

    assign mem_read0_write1 = mem_rw_q;
    assign mem_addr         = mem_addr_q;
    assign mem_byteenable   = mem_be_q;
    assign mem_write_data   = mem_wd_q;
    assign req0_ack         = ack_q[0];
    assign req1_ack         = ack_q[1];
    assign req0_read_data   = rdata_q[0];
    assign req1_read_data   = rdata_q[1];
    assign grant_id         = grant_id_q;
    assign timeout_error    = timeout_error_q;
    assign protocol_error   = protocol_error_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter
module tb_dram_arbiter;

    localparam int AB = 24;
    localparam int XL = 32;
    localparam int BE = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          req0_cs, req0_read0_write1, req1_cs, req1_read0_write1;
    logic [AB-1:0] req0_addr, req1_addr;
    logic [BE-1:0] req0_byteenable, req1_byteenable;
    logic [XL-1:0] req0_write_data, req1_write_data;
    logic          req0_ack, req1_ack;
    logic [XL-1:0] req0_read_data, req1_read_data;
    logic          mem_cs, mem_read0_write1, mem_ack;
    logic [AB-1:0] mem_addr;
    logic [BE-1:0] mem_byteenable;
    logic [XL-1:0] mem_write_data, mem_read_data;
    logic          busy, grant_id, timeout_error;
    logic [1:0]    protocol_error;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_BITS(AB), .XLEN(XL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .req0_cs(req0_cs), .req0_read0_write1(req0_read0_write1), .req0_addr(req0_addr),
        .req0_byteenable(req0_byteenable), .req0_write_data(req0_write_data),
        .req0_ack(req0_ack), .req0_read_data(req0_read_data),
        .req1_cs(req1_cs), .req1_read0_write1(req1_read0_write1), .req1_addr(req1_addr),
        .req1_byteenable(req1_byteenable), .req1_write_data(req1_write_data),
        .req1_ack(req1_ack), .req1_read_data(req1_read_data),
        .mem_cs(mem_cs), .mem_read0_write1(mem_read0_write1), .mem_addr(mem_addr),
        .mem_byteenable(mem_byteenable), .mem_write_data(mem_write_data),
        .mem_ack(mem_ack), .mem_read_data(mem_read_data),
        .busy(busy), .grant_id(grant_id), .timeout_error(timeout_error),
        .protocol_error(protocol_error)
    );

    typedef struct {
        int            port;
        logic          rw;
        logic [AB-1:0] addr;
        logic [BE-1:0] be;
        logic [XL-1:0] wd;
        int            at;
    } cmd_t;

    typedef struct {
        int            port;
        logic [XL-1:0] data;
        int            at;
    } ack_t;

    cmd_t          cmd_q[$];
    ack_t          ack_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            ack_at   = -1;
    int            ack_delay = 6;
    bit            mem_respond = 1'b1;
    logic [XL-1:0] ack_data;
    logic [XL-1:0] fixed_resp = '0;
    int            rr_left[2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send(input int p, input logic rw, input logic [AB-1:0] a, input logic [BE-1:0] be,
                        input logic [XL-1:0] wd, input int at, input bit expect_issue);
        cmd_t c;
        if (p == 0) begin
            req0_read0_write1 = rw; req0_addr = a; req0_byteenable = be; req0_write_data = wd; req0_cs = 1'b1;
        end else begin
            req1_read0_write1 = rw; req1_addr = a; req1_byteenable = be; req1_write_data = wd; req1_cs = 1'b1;
        end
        if (expect_issue) begin
            c.port = p; c.rw = rw; c.addr = a; c.be = be; c.wd = wd; c.at = at;
            cmd_q.push_back(c);
        end
    endtask

    task automatic send_random(input int p);
        logic [AB-1:0] a;
        logic [BE-1:0] be;
        logic [XL-1:0] wd;
        logic          rw;
        a  = AB'($urandom);
        be = BE'($urandom);
        wd = $urandom;
        rw = 1'($urandom_range(0, 1));
        send(p, rw, a, be, wd, -1, 1'b1);
    endtask

    // One cycle: mid-cycle sample of DUT outputs, controller model, then drive this cycle's inputs.
    task automatic tick();
        cmd_t          c;
        ack_t          a;
        logic [XL-1:0] resp;
        logic          ack_seen;
        logic [XL-1:0] rd_seen;
        @(negedge clk);
        cyc++;
        req0_cs = 1'b0;
        req1_cs = 1'b0;
        mem_ack = 1'b0;

        if (mem_cs) begin
            check_eq("mem_cs_expected", 64'(cmd_q.size() > 0), 64'd1);
            if (cmd_q.size() > 0) begin
                c = cmd_q.pop_front();
                check_eq("grant_id", grant_id, c.port);
                check_eq("mem_rw", mem_read0_write1, c.rw);
                check_eq("mem_addr", mem_addr, c.addr);
                check_eq("mem_be", mem_byteenable, c.be);
                check_eq("mem_wdata", mem_write_data, c.wd);
                if (c.at >= 0) check_eq("issue_cycle", cyc, c.at);
                resp = (fixed_resp != 0) ? fixed_resp : ({8'hD0, c.addr} ^ XL'(cyc));
                if (mem_respond) begin
                    ack_at   = cyc + ack_delay;
                    ack_data = resp;
                    a.port = c.port; a.data = resp; a.at = ack_at + 1;
                end else begin
                    a.port = c.port; a.data = '0; a.at = cyc + TO + 1;
                end
                ack_q.push_back(a);
            end
        end

        for (int p = 0; p < 2; p++) begin
            ack_seen = (p == 0) ? req0_ack : req1_ack;
            rd_seen  = (p == 0) ? req0_read_data : req1_read_data;
            if (ack_seen) begin
                check_eq("ack_expected", 64'(ack_q.size() > 0), 64'd1);
                if (ack_q.size() > 0) begin
                    a = ack_q.pop_front();
                    check_eq("ack_port", p, a.port);
                    check_eq("ack_data", rd_seen, a.data);
                    check_eq("ack_cycle", cyc, a.at);
                end
                if (rr_left[p] > 0) begin
                    rr_left[p]--;
                    send_random(p);
                end
            end
        end

        if (cyc == ack_at) begin
            mem_ack       = 1'b1;
            mem_read_data = ack_data;
            ack_at        = -1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (((cmd_q.size() + ack_q.size()) != 0) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq("drain_in_budget", cmd_q.size() + ack_q.size(), 0);
        ticks(3);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        sync_reset = 1'b1;
        req0_cs = 0; req0_read0_write1 = 0; req0_addr = '0; req0_byteenable = '0; req0_write_data = '0;
        req1_cs = 0; req1_read0_write1 = 0; req1_addr = '0; req1_byteenable = '0; req1_write_data = '0;
        mem_ack = 0; mem_read_data = '0;

        // Reset state
        ticks(3);
        check_eq("rst_mem_cs", mem_cs, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_timeout", timeout_error, 0);
        check_eq("rst_proto", protocol_error, 0);
        check_eq("rst_acks", {req1_ack, req0_ack}, 0);
        check_eq("rst_rdata0", req0_read_data, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_fields", {mem_read0_write1, mem_byteenable, mem_write_data}, 0);
        sync_reset = 1'b0;

        // Single read on port 0: cs at 10, mem_cs at 11, mem_ack at 17, req0_ack at 18
        while (cyc < 10) tick();
        fixed_resp = 32'hCAFEF00D;
        ack_delay  = 6;
        send(0, 1'b0, 24'h000123, 4'hF, 32'h0, 11, 1'b1);
        tick();
        check_eq("busy_after_req", busy, 1);
        drain(50);
        check_eq("rd0_holds", req0_read_data, 32'hCAFEF00D);
        fixed_resp = '0;

        // Port 1 write with byte enables
        send(1, 1'b1, 24'h00ABCD, 4'b0101, 32'h11223344, cyc + 1, 1'b1);
        drain(50);

        // Tie then round-robin, 20 transactions per port with immediate re-request
        ack_delay = 3;
        rr_left   = '{19, 19};
        send(0, 1'b0, 24'h000010, 4'hF, 32'h0, cyc + 1, 1'b1);
        send(1, 1'b0, 24'h000020, 4'hF, 32'h0, -1, 1'b1);
        drain(2000);
        check_eq("rr_done", rr_left[0] + rr_left[1], 0);
        check_eq("rr_no_proto", protocol_error, 0);

        // Protocol violation: second req0_cs while port 0 is in flight
        ack_delay = 6;
        send(0, 1'b0, 24'h000777, 4'hF, 32'h0, cyc + 1, 1'b1);
        ticks(3);
        send(0, 1'b1, 24'h000888, 4'h3, 32'h55AA55AA, -1, 1'b0);
        drain(50);
        check_eq("proto_err", protocol_error, 2'b01);

        // Timeout on port 1, then a stray mem_ack while idle
        mem_respond = 1'b0;
        send(1, 1'b0, 24'h000999, 4'hF, 32'h0, cyc + 1, 1'b1);
        drain(100);
        check_eq("timeout_err", timeout_error, 1);
        mem_respond = 1'b1;
        tick();
        mem_ack       = 1'b1;
        mem_read_data = 32'hFFFF_FFFF;
        ticks(4);
        check_eq("stray_busy", busy, 0);
        check_eq("stray_rd1", req1_read_data, 0);
        check_eq("stray_sticky", {timeout_error, protocol_error}, 3'b101);

        // Reset during WAIT_ACK
        ack_delay = 8;
        send(0, 1'b0, 24'h000444, 4'hF, 32'h0, cyc + 1, 1'b1);
        ticks(3);
        check_eq("pre_rst_busy", busy, 1);
        ack_at = -1;
        ack_q.delete();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_flags", {timeout_error, protocol_error}, 0);
        check_eq("mid_rst_mem", {mem_cs, mem_addr}, 0);
        check_eq("mid_rst_acks", {req1_ack, req0_ack}, 0);
        ticks(12);
        ack_delay = 2;
        send(1, 1'b0, 24'h000555, 4'hF, 32'h0, cyc + 1, 1'b1);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
